fht_loader: RTL and testbench
=============================

# fht_loader

Input frame loader for `fht_top`. It accepts a stream of signed ADC samples over a valid/ready handshake and writes one frame of N = 4·2^A_BIT samples into the four FHT RAM banks, with optional bit-reversed ordering. When the frame is complete it pulses the transform start, then holds off new samples until the FHT reports ready. It sits directly upstream of `fht_top` and drives its `iWE`, `iDATA_x`, `iADDR_WR_x` and `iSTART`.

## Interface
- `D_BIT`, default 16: sample width, equal to the FHT data width.
- `A_BIT`, default 8: bank address width; bank size 2^A_BIT; frame length N = 2^(A_BIT+2).
- `BITREV`, default 1: 1 writes samples in bit-reversed index order; 0 writes them in natural order.
- `iCLK`  in  1  clock; all logic on the rising edge.
- `iRESET`  in  1  asynchronous, active-high reset.
- `iDATA`  in  D_BIT  signed ADC sample.
- `iVALID`  in  1  `iDATA` is valid.
- `oREADY`  out  1  loader accepts a sample; transfer occurs when `iVALID & oREADY`.
- `iFHT_RDY`  in  1  `fht_top` `oRDY`; low while a transform runs, high when done.
- `oWE`  out  4  one-hot bank write enable, to `iWE`.
- `oDATA`  out  D_BIT  write data, fanned out to `iDATA_0..3`.
- `oADDR_WR`  out  A_BIT  bank write address, fanned out to `iADDR_WR_0..3`.
- `oSTART`  out  1  one-cycle transform start pulse, to `iSTART`.
- `oBUSY`  out  1  high from the first accepted sample of a frame until the transform completes.

## Operation
- Sample counter `k` has A_BIT+2 bits.
  - Mapped index `j = BITREV ? bitrev(k) : k`.
  - Bank = `j[A_BIT+1:A_BIT]`; address = `j[A_BIT-1:0]`.
- FSM states: LOAD, FLUSH, START, WAIT_ACK, WAIT_DONE. Reset state is LOAD.
- LOAD: `oREADY=1`.
  - On each accept: register `iDATA`, set the `oWE` bank bit, register the address, increment `k`.
  - Accept with `k==N-1`: `k` wraps to 0 and the FSM goes to FLUSH.
- FLUSH: `oREADY=0`. The last write is on the bus this cycle. Next state is START.
- START: `oSTART=1` for exactly one cycle. Next state is WAIT_ACK.
- WAIT_ACK: wait for `iFHT_RDY==0`, then go to WAIT_DONE. This guards against a stale high `oRDY`.
- WAIT_DONE: wait for `iFHT_RDY==1`, then go to LOAD.
- `oBUSY`:
  - Set on the first accept of a frame (`k==0`).
  - Cleared on the WAIT_DONE→LOAD transition.
- Outside LOAD nothing is written: `oWE=0`, and `iDATA` is ignored.
- `oDATA` and `oADDR_WR` hold their last value when `oWE=0`.

## Timing
- Reset values: `oREADY=1`, `oWE=0`, `oDATA=0`, `oADDR_WR=0`, `oSTART=0`, `oBUSY=0`, `k=0`, state LOAD.
- Reset mid-frame discards the partial frame. The next accepted sample goes to index 0.
- Write latency is one cycle: a sample accepted at edge E drives `oWE/oDATA/oADDR_WR` during the cycle after E, and the RAM captures it at E+1.
- Last sample accepted at edge E:
  - `oREADY` is low from E.
  - Final write is captured at E+1.
  - `oSTART` is high between E+1 and E+2.
- Back-to-back accepts give one write per cycle with no bubbles.
- Gaps in `iVALID` produce `oWE=0` cycles; `k` does not advance during a gap.
- The earliest new-frame accept is the cycle after `iFHT_RDY` is sampled high in WAIT_DONE.
- `iFHT_RDY` already low on entry to WAIT_ACK: advance to WAIT_DONE after one cycle.

## Structure
- Shared package `fht_pkg`:
  - FSM state enum `loader_state_t`.
  - Function `bitrev(value, width)`.
  - Constant `N_BANK = 4`.
- One sub-module, `fht_loader_addr`: takes `k`, returns the bank one-hot and address. It is purely combinational; the parent registers its outputs.

## Test plan
Bench uses A_BIT=3, so N=32 and bank size is 8.
- BITREV=0, samples 100+k, `iVALID` held high → k=9 writes `oWE=4'b0010`, `oADDR_WR=1`, `oDATA=109`; k=31 writes `4'b1000`, addr 7. `oSTART` is a single pulse one cycle after the k=31 write.
- BITREV=1, same stream → k=1 (j=16) writes bank 2 (`4'b0100`), addr 0, data 101; k=3 (j=24) writes bank 3, addr 0.
- `iVALID` asserted one cycle in three → exactly 32 writes, and no `oWE` in gap cycles. The final RAM image matches the BITREV=1 mapping.
- Hold `iVALID` high through WAIT_ACK/WAIT_DONE; drive `iFHT_RDY` 1→0 (3 cycles later) →1 (50 cycles later) → `oREADY=0` and `oWE=0` throughout. The first new accept is one cycle after `iFHT_RDY` rises, and it writes index 0.
- Assert `iRESET` after 10 accepts → all outputs return to reset values asynchronously. The next frame's first sample is written to j=0 (bank 0, addr 0), and no `oSTART` occurs for the discarded frame.
- `iFHT_RDY` held low before `oSTART` → WAIT_ACK exits after one cycle, and the FSM waits in WAIT_DONE until it rises.

Source files
------------

// File: rtl/fht_pkg.sv
// Shared definitions for the FHT input path: loader FSM states, bank count, index bit-reversal.
// Pure declarations, no latency or flow control of its own.
package fht_pkg;

  localparam int N_BANK = 4;

  typedef enum logic [2:0] {
    LOAD,
    FLUSH,
    START,
    WAIT_ACK,
    WAIT_DONE
  } loader_state_t;

  // Reverses the low `width` bits of `value`; bits above `width` come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_loader_addr.sv
// Maps sample counter k to a one-hot RAM bank and bank address, optionally bit-reversed.
// Purely combinational; the parent registers both outputs and applies any flow control.
module fht_loader_addr
  import fht_pkg::*;
#(
  parameter int A_BIT  = 8,
  parameter int BITREV = 1
) (
  input  logic [A_BIT+1:0]  k,
  output logic [N_BANK-1:0] bank_oh,
  output logic [A_BIT-1:0]  addr
);

  logic [A_BIT+1:0] j;

  always_comb begin
    if (BITREV != 0) begin
      j = (A_BIT+2)'(bitrev(32'(k), A_BIT + 2));
    end else begin
      j = k;
    end
    bank_oh = '0;
    bank_oh[j[A_BIT+1:A_BIT]] = 1'b1;
    addr = j[A_BIT-1:0];
  end

endmodule

// File: rtl/fht_loader.sv
// Loads one frame of 4*2^A_BIT samples into the FHT banks, then starts the transform; write latency 1 cycle.
// oREADY is high only while loading; it stays low from the last accept until the FHT reports done.
module fht_loader
  import fht_pkg::*;
#(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 8,
  parameter int BITREV = 1
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic signed [D_BIT-1:0] iDATA,
  input  logic                    iVALID,
  output logic                    oREADY,
  input  logic                    iFHT_RDY,
  output logic [N_BANK-1:0]       oWE,
  output logic signed [D_BIT-1:0] oDATA,
  output logic [A_BIT-1:0]        oADDR_WR,
  output logic                    oSTART,
  output logic                    oBUSY
);

  loader_state_t state, state_nxt;

  logic [A_BIT+1:0]  k;
  logic [N_BANK-1:0] bank_oh;
  logic [A_BIT-1:0]  addr;
  logic              accept;
  logic              k_last;

  assign accept = iVALID & oREADY;
  assign k_last = (k == '1);

  fht_loader_addr #(
    .A_BIT  (A_BIT),
    .BITREV (BITREV)
  ) u_addr (
    .k       (k),
    .bank_oh (bank_oh),
    .addr    (addr)
  );

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // WAIT_ACK must see the FHT go busy first, so a stale high ready cannot end the wait early.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:      if (accept && k_last) state_nxt = FLUSH;
      FLUSH:     state_nxt = START;
      START:     state_nxt = WAIT_ACK;
      WAIT_ACK:  if (!iFHT_RDY) state_nxt = WAIT_DONE;
      WAIT_DONE: if (iFHT_RDY) state_nxt = LOAD;
      default:   state_nxt = LOAD;
    endcase
  end

  always_comb begin
    oREADY = (state == LOAD);
    oSTART = (state == START);
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      k        <= '0;
      oWE      <= '0;
      oDATA    <= '0;
      oADDR_WR <= '0;
      oBUSY    <= 1'b0;
    end else begin
      oWE <= accept ? bank_oh : '0;
      if (accept) begin
        oDATA    <= iDATA;
        oADDR_WR <= addr;
        k        <= k + 1'b1;
      end
      if (accept && (k == '0)) begin
        oBUSY <= 1'b1;
      end else if ((state == WAIT_DONE) && iFHT_RDY) begin
        oBUSY <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fht_loader.sv
// Directed bench for fht_loader: natural and bit-reversed DUTs on shared stimulus, checked against a frame-level model.
module tb_fht_loader;
  localparam int DB = 16;
  localparam int AB = 3;
  localparam int NS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic fht_rdy = 1'b1;
  logic signed [DB-1:0] din = '0;

  logic rdy0, rdy1, st0, st1, bz0, bz1;
  logic [3:0] we0, we1;
  logic signed [DB-1:0] do0, do1;
  logic [AB-1:0] ad0, ad1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fht_loader #(.D_BIT(DB), .A_BIT(AB), .BITREV(0)) u0 (
    .iCLK(clk), .iRESET(rst), .iDATA(din), .iVALID(valid), .oREADY(rdy0),
    .iFHT_RDY(fht_rdy), .oWE(we0), .oDATA(do0), .oADDR_WR(ad0), .oSTART(st0), .oBUSY(bz0)
  );

  fht_loader #(.D_BIT(DB), .A_BIT(AB), .BITREV(1)) u1 (
    .iCLK(clk), .iRESET(rst), .iDATA(din), .iVALID(valid), .oREADY(rdy1),
    .iFHT_RDY(fht_rdy), .oWE(we1), .oDATA(do1), .oADDR_WR(ad1), .oSTART(st1), .oBUSY(bz1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev5(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 5; i++) if (v[i]) r = r | (1 << (4 - i));
    return r;
  endfunction

  // Frame-level model: phase 0 loading, 1 last write on bus, 2 start pulse, 3 wait for FHT busy, 4 wait for FHT done.
  int m_phase = 0;
  int m_cnt = 0;
  logic m_busy = 1'b0;
  logic [3:0] m_we0 = '0, m_we1 = '0;
  logic [2:0] m_ad0 = '0, m_ad1 = '0;
  logic signed [DB-1:0] m_dat = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_cnt <= 0; m_busy <= 1'b0;
      m_we0 <= '0; m_we1 <= '0; m_ad0 <= '0; m_ad1 <= '0; m_dat <= '0;
    end else begin
      m_we0 <= '0;
      m_we1 <= '0;
      case (m_phase)
        0: if (valid) begin
          m_we0 <= 4'(1 << (m_cnt / 8));
          m_ad0 <= 3'(m_cnt % 8);
          m_we1 <= 4'(1 << (rev5(m_cnt) / 8));
          m_ad1 <= 3'(rev5(m_cnt) % 8);
          m_dat <= din;
          if (m_cnt == 0) m_busy <= 1'b1;
          if (m_cnt == NS - 1) begin
            m_cnt <= 0;
            m_phase <= 1;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        1: m_phase <= 2;
        2: m_phase <= 3;
        3: if (!fht_rdy) m_phase <= 4;
        4: if (fht_rdy) begin
          m_phase <= 0;
          m_busy <= 1'b0;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready0", 32'(rdy0), 32'(m_phase == 0));
      chk("ready1", 32'(rdy1), 32'(m_phase == 0));
      chk("start0", 32'(st0), 32'(m_phase == 2));
      chk("start1", 32'(st1), 32'(m_phase == 2));
      chk("busy0", 32'(bz0), 32'(m_busy));
      chk("busy1", 32'(bz1), 32'(m_busy));
      chk("we0", 32'(we0), 32'(m_we0));
      chk("we1", 32'(we1), 32'(m_we1));
      chk("addr0", 32'(ad0), 32'(m_ad0));
      chk("addr1", 32'(ad1), 32'(m_ad1));
      chk("data0", 32'(do0), 32'(m_dat));
      chk("data1", 32'(do1), 32'(m_dat));
    end
  end

  // RAM image of the bit-reversed DUT, plus write and start-pulse counters.
  logic clr = 1'b1;
  int wr_cnt = 0;
  int start_cnt = 0;
  logic signed [DB-1:0] ram1 [4][8];

  always @(posedge clk) begin
    if (clr) begin
      wr_cnt <= 0;
      for (int b = 0; b < 4; b++) for (int a = 0; a < 8; a++) ram1[b][a] <= '0;
    end else if (we1 != 4'b0) begin
      wr_cnt <= wr_cnt + 1;
      for (int b = 0; b < 4; b++) if (we1[b]) ram1[b][ad1] <= do1;
    end
  end

  always @(negedge clk) if (st0) start_cnt <= start_cnt + 1;

  task automatic push(input int d);
    bit acc;
    acc = 1'b0;
    valid = 1'b1;
    din = DB'(d);
    for (int t = 0; t < 200 && !acc; t++) begin
      acc = rdy0;
      @(negedge clk);
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got no accept expected accept for data %0d", d);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready0"}, 32'(rdy0), 1);
    chk({tag, "_ready1"}, 32'(rdy1), 1);
    chk({tag, "_we0"}, 32'(we0), 0);
    chk({tag, "_we1"}, 32'(we1), 0);
    chk({tag, "_data0"}, 32'(do0), 0);
    chk({tag, "_addr1"}, 32'(ad1), 0);
    chk({tag, "_start0"}, 32'(st0), 0);
    chk({tag, "_busy0"}, 32'(bz0), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    #2 rst = 1'b0;
    @(negedge clk);
    clr = 1'b0;

    // Frame 1: continuous stream 100+k.
    for (int k = 0; k < NS; k++) begin
      push(100 + k);
      if (k == 1) begin
        chk("k1_we_rev", 32'(we1), 32'h4);
        chk("k1_addr_rev", 32'(ad1), 0);
        chk("k1_data_rev", 32'(do1), 101);
      end
      if (k == 3) begin
        chk("k3_we_rev", 32'(we1), 32'h8);
        chk("k3_addr_rev", 32'(ad1), 0);
      end
      if (k == 9) begin
        chk("k9_we_nat", 32'(we0), 32'h2);
        chk("k9_addr_nat", 32'(ad0), 1);
        chk("k9_data_nat", 32'(do0), 109);
      end
      if (k == 31) begin
        chk("k31_we_nat", 32'(we0), 32'h8);
        chk("k31_addr_nat", 32'(ad0), 7);
      end
    end
    din = DB'(300);
    chk("last_ready_low", 32'(rdy0), 0);
    @(negedge clk);
    chk("start_after_last", 32'(st0), 1);
    @(negedge clk);
    chk("start_single", 32'(st0), 0);
    repeat (2) @(negedge clk);
    fht_rdy = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (49) @(negedge clk);
    chk("wait_ready_low", 32'(rdy0), 0);
    chk("wait_busy", 32'(bz0), 1);
    fht_rdy = 1'b1;
    @(negedge clk);
    chk("done_ready", 32'(rdy0), 1);
    chk("done_busy", 32'(bz0), 0);
    @(negedge clk);
    chk("f2_first_we", 32'(we1), 32'h1);
    chk("f2_first_addr", 32'(ad1), 0);
    chk("f2_first_data", 32'(do0), 300);

    // Frame 2: valid one cycle in three; FHT ready already low before the start pulse.
    for (int k = 1; k < NS; k++) begin
      valid = 1'b0;
      repeat (2) @(negedge clk);
      push(300 + k);
    end
    valid = 1'b0;
    fht_rdy = 1'b0;
    repeat (12) @(negedge clk);
    chk("hold_ready_low", 32'(rdy0), 0);
    chk("hold_busy", 32'(bz0), 1);
    chk("start_count_f2", 32'(start_cnt), 2);
    chk("write_count_f2", 32'(wr_cnt), 32);
    for (int k = 0; k < NS; k++) begin
      chk($sformatf("ram_k%0d", k), 32'(ram1[rev5(k) / 8][rev5(k) % 8]), 32'(300 + k));
    end
    fht_rdy = 1'b1;
    @(negedge clk);
    chk("f2_done_ready", 32'(rdy0), 1);

    // Reset after 10 accepts discards the partial frame.
    for (int k = 0; k < 10; k++) push(500 + k);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NS; k++) begin
      push(700 + k);
      if (k == 0) begin
        chk("f3_first_we_nat", 32'(we0), 32'h1);
        chk("f3_first_we_rev", 32'(we1), 32'h1);
        chk("f3_first_addr", 32'(ad1), 0);
        chk("f3_first_data", 32'(do1), 700);
      end
    end
    valid = 1'b0;
    chk("no_start_discarded", 32'(start_cnt), 2);
    repeat (3) @(negedge clk);
    chk("start_count_f3", 32'(start_cnt), 3);
    fht_rdy = 1'b0;
    repeat (3) @(negedge clk);
    fht_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("f3_done_ready", 32'(rdy0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
